// File: rtl/me_stage_pkg.sv
// Shared definitions for the ME stage: opcode and access-size codes, FSM states, op classes.
// Imported by me_stage and me_lane.
package me_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_MLOAD  = 7'b0001011;
  localparam logic [6:0] OP_MSTORE = 7'b0101011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} me_state_e;

  typedef enum logic [2:0] {
    K_NONE, K_LOAD, K_STORE, K_FLW, K_FSW, K_MLOAD, K_MSTORE
  } mem_kind_e;

  function automatic mem_kind_e decode_kind(input logic [6:0] op);
    case (op)
      OP_LOAD:   return K_LOAD;
      OP_STORE:  return K_STORE;
      OP_FLW:    return K_FLW;
      OP_FSW:    return K_FSW;
      OP_MLOAD:  return K_MLOAD;
      OP_MSTORE: return K_MSTORE;
      default:   return K_NONE;
    endcase
  endfunction

endpackage

// File: rtl/me_lane.sv
// Byte-lane steering for the ME stage: store data replication/byte enables and load extract/extend.
// Purely combinational; lanes wrap modulo 4 inside the word, misaligned accesses are never split.
module me_lane
  import me_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic        i_full,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_base_mask;
  logic [7:0]  w_mask8;
  logic [15:0] w_rot;

  always_comb begin
    o_wdata     = i_st_data;
    w_base_mask = 4'b1111;
    if (!i_full) begin
      case (i_funct3)
        F3_B: begin
          o_wdata     = {4{i_st_data[7:0]}};
          w_base_mask = 4'b0001;
        end
        F3_H: begin
          o_wdata     = {2{i_st_data[15:0]}};
          w_base_mask = 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Shift into an 8-bit window and fold the top back so halfword enables rotate around the word.
  assign w_mask8 = {4'b0000, w_base_mask} << i_lane;
  assign o_wmask = w_mask8[7:4] | w_mask8[3:0];

  always_comb begin
    case (i_lane)
      2'd1:    w_rot = i_ld_word[23:8];
      2'd2:    w_rot = i_ld_word[31:16];
      2'd3:    w_rot = {i_ld_word[7:0], i_ld_word[31:24]};
      default: w_rot = i_ld_word[15:0];
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_word;
    if (!i_full) begin
      case (i_funct3)
        F3_B:    o_ld_data = {{24{w_rot[7]}}, w_rot[7:0]};
        F3_H:    o_ld_data = {{16{w_rot[15]}}, w_rot};
        F3_BU:   o_ld_data = {24'd0, w_rot[7:0]};
        F3_HU:   o_ld_data = {16'd0, w_rot};
        F3_W:    o_ld_data = i_ld_word;
        default: o_ld_data = i_ld_word;
      endcase
    end
  end

endmodule

// File: rtl/me_stage.sv
// Memory-access stage: scalar and 512-bit matrix loads/stores over a 32-bit req/gnt/rvalid port.
// Non-memory ops take 1 cycle; memory ops hold ready low until done; a stalled WB result blocks accept.
module me_stage
  import me_stage_pkg::*;
#(
  parameter int M_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EX_valid,
  output logic         ready,
  output logic         valid,
  input  logic         WB_ready,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [1:0]   rd_group,
  input  logic [4:0]   rd_index,
  input  logic [31:0]  npc,
  input  logic [31:0]  res_R,
  input  logic [31:0]  res_F,
  input  logic [511:0] res_M,
  input  logic [31:0]  rs2_R,
  input  logic [31:0]  rs2_F,
  input  logic [511:0] rs2_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wmask,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic [1:0]   wb_rd_group,
  output logic [4:0]   wb_rd_index,
  output logic [31:0]  wb_npc,
  output logic [31:0]  wb_R,
  output logic [31:0]  wb_F,
  output logic [511:0] wb_M
);

  me_state_e    r_state;
  mem_kind_e    r_kind;
  logic [3:0]   r_beat;
  logic [2:0]   r_funct3;
  logic [31:0]  r_base;
  logic [31:0]  r_st_R;
  logic [31:0]  r_st_F;
  logic [511:0] r_st_M;
  logic         r_valid;
  logic [1:0]   r_wb_grp;
  logic [4:0]   r_wb_idx;
  logic [31:0]  r_wb_npc;
  logic [31:0]  r_wb_R;
  logic [31:0]  r_wb_F;
  logic [511:0] r_wb_M;

  mem_kind_e    w_kind;
  logic         w_accept;
  logic         w_store;
  logic         w_matrix;
  logic         w_full;
  logic [3:0]   w_last;
  logic [31:0]  w_addr;
  logic [31:0]  w_st_word;
  logic [31:0]  w_wdata;
  logic [3:0]   w_wmask;
  logic [31:0]  w_ld_data;

  assign w_kind   = decode_kind(opcode);
  assign ready    = (r_state == ST_IDLE) && (!r_valid || WB_ready);
  assign w_accept = EX_valid && ready;

  assign w_store  = (r_kind == K_STORE) || (r_kind == K_FSW) || (r_kind == K_MSTORE);
  assign w_matrix = (r_kind == K_MLOAD) || (r_kind == K_MSTORE);
  assign w_full   = w_matrix || (r_kind == K_FLW) || (r_kind == K_FSW);
  assign w_last   = w_matrix ? 4'(M_BEATS - 1) : 4'd0;
  assign w_addr   = {r_base[31:2], 2'b00} + {26'd0, r_beat, 2'b00};

  always_comb begin
    case (r_kind)
      K_FSW:    w_st_word = r_st_F;
      K_MSTORE: w_st_word = r_st_M[{r_beat, 5'b00000} +: 32];
      default:  w_st_word = r_st_R;
    endcase
  end

  me_lane u_lane (
    .i_funct3  (r_funct3),
    .i_lane    (r_base[1:0]),
    .i_full    (w_full),
    .i_st_data (w_st_word),
    .i_ld_word (mem_rdata),
    .o_wdata   (w_wdata),
    .o_wmask   (w_wmask),
    .o_ld_data (w_ld_data)
  );

  // Request fields come from registers held across the whole REQ state, so they stay stable until gnt.
  assign mem_req   = (r_state == ST_REQ);
  assign mem_we    = mem_req && w_store;
  assign mem_addr  = mem_req ? w_addr  : 32'd0;
  assign mem_wdata = mem_req ? w_wdata : 32'd0;
  assign mem_wmask = mem_req ? w_wmask : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_kind   <= K_NONE;
      r_beat   <= 4'd0;
      r_funct3 <= 3'd0;
      r_base   <= 32'd0;
      r_st_R   <= 32'd0;
      r_st_F   <= 32'd0;
      r_st_M   <= '0;
      r_valid  <= 1'b0;
      r_wb_grp <= 2'd0;
      r_wb_idx <= 5'd0;
      r_wb_npc <= 32'd0;
      r_wb_R   <= 32'd0;
      r_wb_F   <= 32'd0;
      r_wb_M   <= '0;
    end else begin
      if (r_valid && WB_ready && !w_accept)
        r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wb_grp <= rd_group;
            r_wb_idx <= rd_index;
            r_wb_npc <= npc;
            if (w_kind == K_NONE) begin
              r_valid <= 1'b1;
              r_wb_R  <= res_R;
              r_wb_F  <= res_F;
              r_wb_M  <= res_M;
            end else begin
              r_valid  <= 1'b0;
              r_kind   <= w_kind;
              r_funct3 <= funct3;
              r_base   <= res_R;
              r_st_R   <= rs2_R;
              r_st_F   <= rs2_F;
              r_st_M   <= rs2_M;
              r_beat   <= 4'd0;
              r_state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            if (!w_store) begin
              r_state <= ST_RESP;
            end else if (r_beat == w_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b1;
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end
        end
        ST_RESP: begin
          if (mem_rvalid) begin
            case (r_kind)
              K_MLOAD: r_wb_M[{r_beat, 5'b00000} +: 32] <= mem_rdata;
              K_FLW:   r_wb_F <= mem_rdata;
              default: r_wb_R <= w_ld_data;
            endcase
            if (r_beat == w_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b1;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_state <= ST_REQ;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign valid       = r_valid;
  assign wb_rd_group = r_wb_grp;
  assign wb_rd_index = r_wb_idx;
  assign wb_npc      = r_wb_npc;
  assign wb_R        = r_wb_R;
  assign wb_F        = r_wb_F;
  assign wb_M        = r_wb_M;

endmodule
